// File: rtl/dcache_store_buffer_if.sv
// Store buffer bus bundle: execute-stage enqueue, load hazard probe,
// status, and the write-request/response pair toward the DCache arbiter.

`ifndef DATA_TYPE__LEN
`define DATA_TYPE__LEN 3
`endif

interface dcache_store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Store enqueue from execute
  logic                       St_Valid;
  logic [55:0]                St_Paddr;
  logic [`DATA_TYPE__LEN-1:0] St_DataType;
  logic [63:0]                St_Data;
  logic                       St_Ready;

  // Load hazard probe
  logic [55:0]                Ld_Check_Paddr;
  logic                       Ld_Hit;

  // Occupancy status
  logic                       Sb_Empty;
  logic [CW-1:0]              Sb_Count;

  // Write request toward the DCache arbiter
  logic                       DCache_WrReq_Valid;
  logic [55:0]                DCache_WrReq_Paddr;
  logic [`DATA_TYPE__LEN-1:0] DCache_WrReq_DataType;
  logic [63:0]                DCache_WrReq_Data;
  logic                       DCache_WrResp_Done;
  logic                       DCache_WrResp_Ready;

  // Environment side: execute stage, load unit and DCache arbiter
  modport master (
    output St_Valid, St_Paddr, St_DataType, St_Data,
    output Ld_Check_Paddr,
    output DCache_WrResp_Done, DCache_WrResp_Ready,
    input  St_Ready, Ld_Hit, Sb_Empty, Sb_Count,
    input  DCache_WrReq_Valid, DCache_WrReq_Paddr,
    input  DCache_WrReq_DataType, DCache_WrReq_Data
  );

  // Store buffer side
  modport slave (
    input  St_Valid, St_Paddr, St_DataType, St_Data,
    input  Ld_Check_Paddr,
    input  DCache_WrResp_Done, DCache_WrResp_Ready,
    output St_Ready, Ld_Hit, Sb_Empty, Sb_Count,
    output DCache_WrReq_Valid, DCache_WrReq_Paddr,
    output DCache_WrReq_DataType, DCache_WrReq_Data
  );
endinterface

// File: rtl/dcache_store_buffer.sv
// DCache store buffer: circular FIFO of pending stores drained one at a
// time into the DCache through an IDLE/ISSUE/GAP handshake FSM, with a
// combinational 8-byte-word overlap check for younger loads.

`ifndef DATA_TYPE__LEN
`define DATA_TYPE__LEN 3
`endif

module dcache_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dcache_store_buffer_if.slave  sb_io
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int DTW = `DATA_TYPE__LEN;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // Word-compare mask: ignore byte offset within the 8-byte word
  localparam logic [55:0] WORD_MASK = {{53{1'b1}}, 3'b000};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Entry storage
  logic [55:0]    paddr_q [DEPTH];
  logic [DTW-1:0] dtype_q [DEPTH];
  logic [63:0]    data_q  [DEPTH];
  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;

  // FIFO bookkeeping
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Drain FSM
  state_e state_q;
  logic   wr_valid_q;
  logic   avail_q;

  logic push_s;
  logic pop_s;
  logic ld_hit_s;

  // Push/pop qualification and next pointer/count/valid-bit values
  always_comb begin
    push_s      = sb_io.St_Valid && (count_q != FULL_CNT);
    pop_s       = (state_q == S_ISSUE) && sb_io.DCache_WrResp_Done;
    ent_valid_d = ent_valid_q;
    if (push_s) begin
      tail_d = tail_q + PW'(1);
      ent_valid_d[tail_q] = 1'b1;
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PW'(1);
      ent_valid_d[head_q] = 1'b0;
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry array, pointers and count; reset discards everything incl. in-flight head
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q     <= '{default: '0};
      dtype_q     <= '{default: '0};
      data_q      <= '{default: '0};
      ent_valid_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      if (push_s) begin
        paddr_q[tail_q] <= sb_io.St_Paddr;
        dtype_q[tail_q] <= sb_io.St_DataType;
        data_q[tail_q]  <= sb_io.St_Data;
      end
      ent_valid_q <= ent_valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Drain FSM with registered request valid. The drain only sees an entry
  // one cycle after it lands (avail_q), so a fresh store issues two edges
  // after its push; after a GAP the IDLE cycle gives the same spacing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_valid_q <= 1'b0;
      avail_q    <= 1'b0;
    end else begin
      avail_q <= (count_q != '0);
      case (state_q)
        S_IDLE: begin
          if (avail_q && (count_q != '0) && sb_io.DCache_WrResp_Ready) begin
            state_q    <= S_ISSUE;
            wr_valid_q <= 1'b1;
          end else begin
            state_q    <= S_IDLE;
            wr_valid_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (sb_io.DCache_WrResp_Done) begin
            state_q    <= S_GAP;
            wr_valid_q <= 1'b0;
          end else begin
            state_q    <= S_ISSUE;
            wr_valid_q <= 1'b1;
          end
        end
        S_GAP: begin
          state_q    <= S_IDLE;
          wr_valid_q <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          wr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Load hazard: any held entry in the same 8-byte word as the probe
  always_comb begin
    ld_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_hit_s = ld_hit_s |
                 (ent_valid_q[i] &&
                  (((paddr_q[i] ^ sb_io.Ld_Check_Paddr) & WORD_MASK) == 56'd0));
    end
  end

  assign sb_io.St_Ready              = (count_q != FULL_CNT);
  assign sb_io.Sb_Empty              = (count_q == '0);
  assign sb_io.Sb_Count              = count_q;
  assign sb_io.Ld_Hit                = ld_hit_s;
  assign sb_io.DCache_WrReq_Valid    = wr_valid_q;
  // Head entry is always presented; only meaningful while Valid is high
  assign sb_io.DCache_WrReq_Paddr    = paddr_q[head_q];
  assign sb_io.DCache_WrReq_DataType = dtype_q[head_q];
  assign sb_io.DCache_WrReq_Data     = data_q[head_q];

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Self-checking bench for dcache_store_buffer: a queue-based reference
// model tracks held stores; directed scenarios plus randomized traffic.

`timescale 1ns/1ps

`ifndef DATA_TYPE__LEN
`define DATA_TYPE__LEN 3
`endif

module tb_dcache_store_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int DTW   = `DATA_TYPE__LEN;

  typedef struct packed {
    logic [55:0]    paddr;
    logic [DTW-1:0] dt;
    logic [63:0]    data;
  } st_t;

  st_t  exp_q[$];
  int   checks;
  int   errors;
  bit   auto_r;
  logic clk;
  logic rst;

  dcache_store_buffer_if #(.DEPTH(DEPTH)) sb_if ();

  dcache_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .sb_io (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_hit(input logic [55:0] a);
    foreach (exp_q[i]) if (exp_q[i].paddr[55:3] == a[55:3]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_rand_store();
    sb_if.St_Paddr    = 56'h10_0000 + 56'($urandom_range(0, 511));
    sb_if.St_DataType = DTW'($urandom_range(0, 7));
    sb_if.St_Data     = {$urandom, $urandom};
  endtask

  // One clock: update model with push/pop at this edge, check status outputs
  task automatic tick(input bit pop);
    bit  do_push;
    st_t cap;
    do_push = (sb_if.St_Valid === 1'b1) && (exp_q.size() < DEPTH) && !rst;
    cap     = '{paddr: sb_if.St_Paddr, dt: sb_if.St_DataType, data: sb_if.St_Data};
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(cap);
    end
    checks++;
    if (sb_if.Sb_Count !== CW'(exp_q.size())) begin
      errors++; $display("FAIL sb_count got %0d want %0d", sb_if.Sb_Count, exp_q.size());
    end
    checks++;
    if (sb_if.St_Ready !== (exp_q.size() != DEPTH)) begin
      errors++; $display("FAIL st_ready got %b want %b", sb_if.St_Ready, exp_q.size() != DEPTH);
    end
    checks++;
    if (sb_if.Sb_Empty !== (exp_q.size() == 0)) begin
      errors++; $display("FAIL sb_empty got %b want %b", sb_if.Sb_Empty, exp_q.size() == 0);
    end
    checks++;
    if (sb_if.Ld_Hit !== model_hit(sb_if.Ld_Check_Paddr)) begin
      errors++; $display("FAIL ld_hit addr %h got %b want %b", sb_if.Ld_Check_Paddr, sb_if.Ld_Hit, model_hit(sb_if.Ld_Check_Paddr));
    end
    if (auto_r) begin
      sb_if.St_Valid = 1'($urandom_range(0, 1));
      drive_rand_store();
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(0, exp_q.size() - 1);
        sb_if.Ld_Check_Paddr = {exp_q[k].paddr[55:3], 3'($urandom_range(0, 7))};
      end else begin
        sb_if.Ld_Check_Paddr = 56'h10_0000 + 56'($urandom_range(0, 511));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
  endtask

  // Wait for a request, hold it lat cycles checking it against the model head,
  // pulse Done (optionally with a simultaneous push), then check GAP and IDLE.
  task automatic serve(input int lat, input bit pod, output int waited);
    int n;
    n = 0;
    while (sb_if.DCache_WrReq_Valid !== 1'b1 && n < 100) begin
      tick(1'b0);
      n++;
    end
    waited = n;
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL serve_timeout got no valid want valid within 100 cycles");
      return;
    end
    for (int c = 0; c < lat; c++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL issue_unexpected got valid=%b want no request (model empty)", sb_if.DCache_WrReq_Valid);
      end else if (sb_if.DCache_WrReq_Valid !== 1'b1 || sb_if.DCache_WrReq_Paddr !== exp_q[0].paddr ||
                   sb_if.DCache_WrReq_DataType !== exp_q[0].dt || sb_if.DCache_WrReq_Data !== exp_q[0].data) begin
        errors++;
        $display("FAIL issue_head got v=%b %h/%h/%h want v=1 %h/%h/%h", sb_if.DCache_WrReq_Valid,
                 sb_if.DCache_WrReq_Paddr, sb_if.DCache_WrReq_DataType, sb_if.DCache_WrReq_Data,
                 exp_q[0].paddr, exp_q[0].dt, exp_q[0].data);
      end
      if (c == lat - 1) begin
        sb_if.DCache_WrResp_Done = 1'b1;
        if (pod) begin
          sb_if.St_Valid = 1'b1;
          drive_rand_store();
        end
      end
      tick(c == lat - 1);
    end
    sb_if.DCache_WrResp_Done = 1'b0;
    if (pod) sb_if.St_Valid = 1'b0;
    checks++;
    if (sb_if.DCache_WrReq_Valid !== 1'b0) begin
      errors++; $display("FAIL gap_valid got %b want 0", sb_if.DCache_WrReq_Valid);
    end
    tick(1'b0);
    checks++;
    if (sb_if.DCache_WrReq_Valid !== 1'b0) begin
      errors++; $display("FAIL idle_valid got %b want 0", sb_if.DCache_WrReq_Valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    checks++;
    if (sb_if.DCache_WrReq_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", sb_if.DCache_WrReq_Valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    sb_if.DCache_WrResp_Ready = 1'b1;
    sb_if.St_Valid = 1'b1; sb_if.St_Paddr = 56'h1000; sb_if.St_DataType = 3'd3; sb_if.St_Data = 64'hAA;
    tick(1'b0);
    sb_if.St_Valid = 1'b0;
    serve(3, 1'b0, n);
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL single_latency got %0d want 2", n);
    end
    checks++;
    if (sb_if.Sb_Empty !== 1'b1) begin
      errors++; $display("FAIL single_empty got %b want 1", sb_if.Sb_Empty);
    end
  endtask

  task automatic test_fill();
    int n;
    do_reset();
    sb_if.DCache_WrResp_Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb_if.St_Valid = 1'b1; sb_if.St_Paddr = 56'h4000 + 56'(8 * i);
      sb_if.St_DataType = 3'(i); sb_if.St_Data = 64'(100 + i);
      tick(1'b0);
    end
    sb_if.St_Valid = 1'b0;
    checks++;
    if (sb_if.St_Ready !== 1'b0 || sb_if.Sb_Count !== CW'(4)) begin
      errors++; $display("FAIL fill_full got ready=%b count=%0d want ready=0 count=4", sb_if.St_Ready, sb_if.Sb_Count);
    end
    for (int i = 0; i < 4; i++) begin
      serve($urandom_range(1, 3), 1'b0, n);
      if (i > 0) begin
        checks++;
        if (n != 1) begin
          errors++; $display("FAIL fill_spacing got %0d want 1", n);
        end
      end
    end
  endtask

  task automatic test_hazard();
    int n;
    do_reset();
    sb_if.DCache_WrResp_Ready = 1'b0;
    sb_if.St_Valid = 1'b1; sb_if.St_Paddr = 56'h2008; sb_if.St_Data = 64'h55;
    tick(1'b0);
    sb_if.St_Valid = 1'b0;
    sb_if.Ld_Check_Paddr = 56'h200F; #1;
    checks++;
    if (sb_if.Ld_Hit !== 1'b1) begin errors++; $display("FAIL hazard_hit got %b want 1", sb_if.Ld_Hit); end
    sb_if.Ld_Check_Paddr = 56'h2010; #1;
    checks++;
    if (sb_if.Ld_Hit !== 1'b0) begin errors++; $display("FAIL hazard_miss got %b want 0", sb_if.Ld_Hit); end
    sb_if.St_Valid = 1'b1; sb_if.St_Paddr = 56'h3000; sb_if.Ld_Check_Paddr = 56'h3004; #1;
    checks++;
    if (sb_if.Ld_Hit !== 1'b0) begin errors++; $display("FAIL hazard_bypass got %b want 0", sb_if.Ld_Hit); end
    tick(1'b0);
    sb_if.St_Valid = 1'b0;
    checks++;
    if (sb_if.Ld_Hit !== 1'b1) begin errors++; $display("FAIL hazard_after_push got %b want 1", sb_if.Ld_Hit); end
    sb_if.Ld_Check_Paddr = 56'h200F;
    sb_if.DCache_WrResp_Ready = 1'b1;
    serve(2, 1'b0, n);
    #1;
    checks++;
    if (sb_if.Ld_Hit !== 1'b0) begin errors++; $display("FAIL hazard_after_pop got %b want 0", sb_if.Ld_Hit); end
    serve(1, 1'b0, n);
  endtask

  task automatic test_ready_low();
    int n;
    do_reset();
    sb_if.DCache_WrResp_Ready = 1'b0;
    sb_if.St_Valid = 1'b1; drive_rand_store();
    tick(1'b0);
    sb_if.St_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      checks++;
      if (sb_if.DCache_WrReq_Valid !== 1'b0) begin
        errors++; $display("FAIL ready_low_valid got %b want 0", sb_if.DCache_WrReq_Valid);
      end
    end
    sb_if.DCache_WrResp_Ready = 1'b1;
    tick(1'b0);
    checks++;
    if (sb_if.DCache_WrReq_Valid !== 1'b1) begin
      errors++; $display("FAIL ready_high_valid got %b want 1", sb_if.DCache_WrReq_Valid);
    end
    serve(1, 1'b0, n);
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    sb_if.DCache_WrResp_Ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb_if.St_Valid = 1'b1; drive_rand_store();
      tick(1'b0);
    end
    sb_if.St_Valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      serve($urandom_range(1, 3), 1'b1, n);
      checks++;
      if (sb_if.Sb_Count !== CW'(2)) begin
        errors++; $display("FAIL wrap_count got %0d want 2", sb_if.Sb_Count);
      end
    end
    for (int i = 0; i < 2; i++) serve(1, 1'b0, n);
  endtask

  task automatic test_reset_issue();
    int n;
    do_reset();
    sb_if.DCache_WrResp_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_if.St_Valid = 1'b1; drive_rand_store();
      tick(1'b0);
    end
    sb_if.St_Valid = 1'b0;
    n = 0;
    while (sb_if.DCache_WrReq_Valid !== 1'b1 && n < 20) begin tick(1'b0); n++; end
    checks++;
    if (sb_if.DCache_WrReq_Valid !== 1'b1 || sb_if.Sb_Count !== CW'(3)) begin
      errors++; $display("FAIL rst_issue_setup got v=%b count=%0d want v=1 count=3", sb_if.DCache_WrReq_Valid, sb_if.Sb_Count);
    end
    rst = 1'b1; sb_if.DCache_WrResp_Done = 1'b1;
    tick(1'b0);
    rst = 1'b0; sb_if.DCache_WrResp_Done = 1'b0;
    checks++;
    if (sb_if.DCache_WrReq_Valid !== 1'b0 || sb_if.Sb_Count !== CW'(0) || sb_if.St_Ready !== 1'b1) begin
      errors++; $display("FAIL rst_issue got v=%b count=%0d ready=%b want v=0 count=0 ready=1",
                         sb_if.DCache_WrReq_Valid, sb_if.Sb_Count, sb_if.St_Ready);
    end
    sb_if.DCache_WrResp_Done = 1'b1;
    tick(1'b0);
    tick(1'b0);
    sb_if.DCache_WrResp_Done = 1'b0;
    checks++;
    if (sb_if.DCache_WrReq_Valid !== 1'b0 || sb_if.Sb_Count !== CW'(0)) begin
      errors++; $display("FAIL spurious_done got v=%b count=%0d want v=0 count=0", sb_if.DCache_WrReq_Valid, sb_if.Sb_Count);
    end
  endtask

  task automatic test_random();
    int n;
    int guard;
    do_reset();
    sb_if.DCache_WrResp_Ready = 1'b1;
    auto_r = 1'b1;
    for (int i = 0; i < 15; i++) serve($urandom_range(1, 4), 1'b0, n);
    auto_r = 1'b0;
    sb_if.St_Valid = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      serve($urandom_range(1, 4), 1'b0, n);
      guard++;
    end
    checks++;
    if (sb_if.Sb_Empty !== 1'b1) begin
      errors++; $display("FAIL random_drain got empty=%b want 1", sb_if.Sb_Empty);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    auto_r = 1'b0;
    rst = 1'b1;
    sb_if.St_Valid            = 1'b0;
    sb_if.St_Paddr            = 56'd0;
    sb_if.St_DataType         = '0;
    sb_if.St_Data             = 64'd0;
    sb_if.Ld_Check_Paddr      = 56'd0;
    sb_if.DCache_WrResp_Done  = 1'b0;
    sb_if.DCache_WrResp_Ready = 1'b1;
    test_reset();
    test_single();
    test_fill();
    test_hazard();
    test_ready_low();
    test_wrap();
    test_reset_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_store_buffer.md
DCACHE_STORE_BUFFER -- requirements
Module: dcache_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port St_Valid  input  1  store-enqueue request from the execute stage.
REQ-005 SHALL have port St_Paddr  input  56  store physical address.
REQ-006 SHALL have port St_DataType  input  `DATA_TYPE__LEN  store access size/type.
REQ-007 SHALL have port St_Data  input  64  store data.
REQ-008 SHALL have port St_Ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port Ld_Check_Paddr  input  56  load address for hazard check.
REQ-010 SHALL have port Ld_Hit  output  1  a buffered store overlaps the load's 8-byte word.
REQ-011 SHALL have port Sb_Empty  output  1  no entries held.
REQ-012 SHALL have port Sb_Count  output  clog2(DEPTH)+1  current entry count.
REQ-013 SHALL have ports DCache_WrReq_Valid (output 1), DCache_WrReq_Paddr (output 56), DCache_WrReq_DataType (output `DATA_TYPE__LEN), DCache_WrReq_Data (output 64): the write-request port into the DCache arbiter.
REQ-014 SHALL have ports DCache_WrResp_Done (input 1, write completed) and DCache_WrResp_Ready (input 1, cache accepting requests).

Function
REQ-015 SHALL hold entries in a circular FIFO (head/tail pointers, count); a store is pushed when St_Valid && St_Ready at a rising edge.
REQ-016 SHALL drive St_Ready = (Sb_Count != DEPTH), from registered count only; a push when full is ignored with no state change.
REQ-017 SHALL implement drain FSM states IDLE, ISSUE, GAP; DCache_WrReq_Valid = (state == ISSUE), registered.
REQ-018 IDLE -> ISSUE when count != 0 and DCache_WrResp_Ready == 1; otherwise remain IDLE.
REQ-019 ISSUE: drive head entry's Paddr/DataType/Data, stable and unchanged until Done; on DCache_WrResp_Done pop head, go to GAP.
REQ-020 GAP: DCache_WrReq_Valid = 0 for exactly one cycle, then IDLE; guarantees the arbiter never sees Valid in the Done cycle's successor for a popped entry.
REQ-021 DCache_WrResp_Done outside ISSUE SHALL be ignored.
REQ-022 Minimum latency: store pushed at edge t into empty buffer -> DCache_WrReq_Valid high from edge t+2; back-to-back entries issue every (Done latency + 2) cycles.
REQ-023 Simultaneous push and pop (non-full) SHALL leave count unchanged, tail and head both advance; pointers wrap modulo DEPTH.
REQ-024 Ld_Hit SHALL be combinational: 1 iff any valid entry (including head in ISSUE) has Paddr[55:3] == Ld_Check_Paddr[55:3]; entry popped at edge t is excluded from t onward.
REQ-025 A store pushed at edge t SHALL participate in Ld_Hit from cycle after t (no same-cycle bypass).
REQ-026 Sb_Empty = (count == 0); Sb_Count registered.
REQ-027 When not in ISSUE, DCache_WrReq_Paddr/DataType/Data SHALL still show head entry (don't-care to consumer, but no X when count != 0).

Reset
REQ-028 With rst high at an edge: state = IDLE, head = tail = count = 0, all entries invalid.
REQ-029 Output values during/after reset: DCache_WrReq_Valid 0, St_Ready 1, Sb_Empty 1, Sb_Count 0, Ld_Hit 0.
REQ-030 Reset mid-ISSUE SHALL discard all entries including the in-flight one; no pop or Done handling that cycle.

Verification
REQ-031 Single store: push Paddr 0x1000, Data 0xAA; Ready=1, Done 3 cycles after Valid -> Valid high at t+2, Paddr/Data stable 0x1000/0xAA until Done, Valid low one cycle after, Sb_Empty=1.
REQ-032 Fill: push DEPTH=4 stores with Done held 0 -> St_Ready 0 after 4th, 5th push ignored, Sb_Count 4; drain -> entries emerge in push order, GAP cycle of Valid=0 between each.
REQ-033 Hazard: buffer holds 0x2008; Ld_Check_Paddr 0x200F -> Ld_Hit 1; 0x2010 -> 0; after its Done pop -> 0x200F gives 0.
REQ-034 Simultaneous push and Done-pop at count 2 -> count stays 2, order preserved across pointer wrap (run 10 stores through DEPTH 4).
REQ-035 Ready low: count 1, DCache_WrResp_Ready 0 for 5 cycles -> Valid stays 0; Ready 1 -> Valid next cycle.
REQ-036 Reset during ISSUE with count 3 -> next cycle Valid 0, Sb_Count 0, St_Ready 1; spurious Done afterward causes no change.
